// File: rtl/temp_value_formatter_if.sv
// Sensor-side and display-side signals of the temperature formatter.
interface temp_value_formatter_if;
   logic        raw_valid;
   logic [15:0] raw_temp;
   logic        sample_req;
   logic [7:0]  c_val;
   logic [7:0]  f_val;
   logic        init;
   logic        upd;
   logic        busy;
   logic        err;

   // Sensor/stimulus side: supplies readings, observes results.
   modport master (
      output raw_valid, raw_temp,
      input  sample_req, c_val, f_val, init, upd, busy, err
   );

   // Formatter side.
   modport slave (
      input  raw_valid, raw_temp,
      output sample_req, c_val, f_val, init, upd, busy, err
   );
endinterface

// File: rtl/temp_value_formatter.sv
// Converts DS18B20-format readings (1/16 degC per LSB) into saturated 8-bit
// Celsius/Fahrenheit values, pacing sensor requests and flagging timeouts.
module temp_value_formatter #(
   parameter int unsigned SAMPLE_PERIOD = 25_000_000,
   parameter int unsigned TIMEOUT       = 1_000_000,
   parameter int unsigned MAX_C         = 99,
   parameter int unsigned MAX_F         = 199
) (
   input logic                   clk,
   input logic                   rst,
   temp_value_formatter_if.slave bus
);

   localparam int unsigned PER_W     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int unsigned TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned DVD_W     = 19;
   localparam int unsigned CNT_W     = 5;
   localparam int unsigned DIV_STEPS = 19;
   localparam int unsigned DIVISOR   = 80;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DIV, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [PER_W-1:0]   per_q, per_d;
   logic               pend_q, pend_d;
   logic               armed_q, armed_d;
   logic [TO_W-1:0]    tcnt_q, tcnt_d;
   logic [15:0]        raw_q, raw_d;
   logic [7:0]         rem_q, rem_d;
   logic [DVD_W-1:0]   dq_q, dq_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sample_req_q, sample_req_d;
   logic [7:0]         c_q, c_d;
   logic [7:0]         f_q, f_d;
   logic               init_q, init_d;
   logic               upd_q, upd_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;

   logic               wrap;
   logic               expire;
   logic signed [20:0] num;
   logic [8:0]         trial;
   logic [10:0]        c_mag;

   // Fahrenheit numerator (F = (raw*9 + 2560) / 80), divider trial and Celsius magnitude.
   assign num   = {{5{raw_q[15]}}, raw_q} * 21'sd9 + 21'sd2560;
   assign trial = {rem_q, dq_q[DVD_W-1]};
   assign c_mag = raw_q[14:4];

   // Next-state and output logic.
   always_comb begin
      state_d      = state_q;
      per_d        = per_q;
      pend_d       = pend_q;
      armed_d      = armed_q;
      tcnt_d       = tcnt_q;
      raw_d        = raw_q;
      rem_d        = rem_q;
      dq_d         = dq_q;
      cnt_d        = cnt_q;
      sample_req_d = 1'b0;
      c_d          = c_q;
      f_d          = f_q;
      init_d       = init_q;
      upd_d        = 1'b0;
      busy_d       = busy_q;
      err_d        = err_q;
      expire       = 1'b0;

      wrap  = (per_q == PER_W'(SAMPLE_PERIOD - 1));
      per_d = wrap ? '0 : per_q + PER_W'(1);

      if (armed_q) begin
         if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
            expire  = 1'b1;
            armed_d = 1'b0;
         end else begin
            tcnt_d = tcnt_q + TO_W'(1);
         end
      end
      if (bus.raw_valid) begin
         armed_d = 1'b0;
      end

      // A wrap seen while converting is held as a single pending request.
      if ((state_q == S_IDLE) && (wrap || pend_q)) begin
         sample_req_d = 1'b1;
         pend_d       = 1'b0;
         armed_d      = 1'b1;
         tcnt_d       = '0;
      end else if (wrap) begin
         pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.raw_valid) begin
               raw_d   = bus.raw_temp;
               busy_d  = 1'b1;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // Non-positive numerators floor to 0 degF; dividing zero keeps it zero.
            dq_d    = (num <= 21'sd0) ? '0 : num[DVD_W-1:0];
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_DIV;
         end
         S_DIV: begin
            if (trial >= 9'(DIVISOR)) begin
               rem_d = 8'(trial - 9'(DIVISOR));
               dq_d  = {dq_q[DVD_W-2:0], 1'b1};
            end else begin
               rem_d = trial[7:0];
               dq_d  = {dq_q[DVD_W-2:0], 1'b0};
            end
            if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (raw_q[15]) begin
               c_d = '0;
            end else if (c_mag > 11'(MAX_C)) begin
               c_d = 8'(MAX_C);
            end else begin
               c_d = 8'(c_mag);
            end
            f_d     = (dq_q > DVD_W'(MAX_F)) ? 8'(MAX_F) : 8'(dq_q);
            upd_d   = 1'b1;
            init_d  = 1'b1;
            err_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A timeout landing on the same cycle still raises the sticky flag.
      if (expire) begin
         err_d = 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         per_q        <= '0;
         pend_q       <= 1'b0;
         armed_q      <= 1'b0;
         tcnt_q       <= '0;
         raw_q        <= '0;
         rem_q        <= '0;
         dq_q         <= '0;
         cnt_q        <= '0;
         sample_req_q <= 1'b0;
         c_q          <= '0;
         f_q          <= '0;
         init_q       <= 1'b0;
         upd_q        <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         per_q        <= per_d;
         pend_q       <= pend_d;
         armed_q      <= armed_d;
         tcnt_q       <= tcnt_d;
         raw_q        <= raw_d;
         rem_q        <= rem_d;
         dq_q         <= dq_d;
         cnt_q        <= cnt_d;
         sample_req_q <= sample_req_d;
         c_q          <= c_d;
         f_q          <= f_d;
         init_q       <= init_d;
         upd_q        <= upd_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   assign bus.sample_req = sample_req_q;
   assign bus.c_val      = c_q;
   assign bus.f_val      = f_q;
   assign bus.init       = init_q;
   assign bus.upd        = upd_q;
   assign bus.busy       = busy_q;
   assign bus.err        = err_q;

endmodule

// File: doc/temp_value_formatter.md
Name: temp_value_formatter

Overview:
Upstream feeder of led_panel_temp_display. It periodically requests a sample from the temperature sensor interface and accepts a raw DS18B20-format reading (signed, 1/16 °C per LSB). It converts the reading into saturated 8-bit Celsius and Fahrenheit integers (c_val, f_val) using a sequential restoring divider. It raises init once the first valid value is available.

Parameters:
SAMPLE_PERIOD, 25_000_000, clk cycles between sample_req pulses (≥ 32).
TIMEOUT, 1_000_000, clk cycles allowed from sample_req to raw_valid before err is set.
MAX_C, 99, Celsius saturation ceiling.
MAX_F, 199, Fahrenheit saturation ceiling.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
raw_valid  input  1  one-cycle strobe; raw_temp is valid.
raw_temp  input  16  signed reading, 1/16 °C per LSB.
sample_req  output  1  one-cycle pulse asking the sensor block for a reading.
c_val  output  8  Celsius, saturated to 0..MAX_C.
f_val  output  8  Fahrenheit, saturated to 0..MAX_F.
init  output  1  0 until the first conversion completes, then 1 until reset.
upd  output  1  one-cycle pulse when c_val/f_val update.
busy  output  1  high while a conversion is in progress.
err  output  1  sticky sensor-timeout flag.

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; period counter 0; timeout counter 0 and disarmed. Reset asserted mid-conversion aborts the conversion; no upd pulse is produced.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 continuously and wraps.
  - On wrap in IDLE: sample_req=1 for one cycle, and the timeout counter is armed and cleared.
  - On wrap while busy: the request is deferred. It issues on the first IDLE cycle, and only one request is ever pending.
- Timeout:
  - While armed, the timeout counter increments each cycle.
  - Reaching TIMEOUT sets err=1 and disarms the counter. c_val, f_val and init hold their values.
  - raw_valid disarms the counter.
- States: IDLE, CALC, DIV, DONE.
  - IDLE: raw_valid=1 latches raw_temp and goes to CALC; busy=1 from the next cycle. raw_valid is accepted even without a prior request.
  - CALC (1 cycle):
    - c = raw_temp >>> 4 (arithmetic, floor).
    - num = raw_temp*9 + 2560, computed as a 21-bit signed value.
    - If num ≤ 0: f_raw = 0 and the divider is skipped (state still walks DIV).
  - DIV (19 cycles): restoring division of num by 80, one quotient bit per cycle, MSB first; quotient is f_raw.
  - DONE (1 cycle):
    - c_val = clamp(c, 0, MAX_C); f_val = clamp(f_raw, 0, MAX_F).
    - upd=1, init=1, err=0, busy=0. Next state IDLE.
- Latency: outputs and upd update on the 21st rising edge after the edge that sampled raw_valid=1.
- raw_valid while busy is ignored and dropped; outputs are unaffected.
- raw_valid coinciding with a timeout expiry: err is set for that cycle and cleared in DONE of the resulting conversion.
- Outputs are registered and hold between updates. The downstream block samples c_val/f_val freely; they never glitch mid-conversion.

Test Plan:
1. Reset for 200 ns then release; raw_valid=1 with raw_temp=0x0190 (25.0 °C) → 21 edges later upd pulses with c_val=25, f_val=77, init=1, busy low again.
2. raw_temp=0x0000 → c_val=0, f_val=32. raw_temp=0x0191 (25.0625 °C) → c_val=25, f_val=77 (floor).
3. Saturation and negatives:
   - raw_temp=0xFF60 (-10 °C) → c_val=0, f_val=14.
   - raw_temp=0xFD80 (-40 °C) → c_val=0, f_val=0.
   - raw_temp=0x07D0 (125 °C) → c_val=99, f_val=199.
4. With SAMPLE_PERIOD=64 and TIMEOUT=40, never answer sample_req → sample_req pulses every 64 cycles. err=1 is set 40 cycles after the first request, and c_val/f_val hold. Next valid reading → err=0 at its upd.
5. Send raw_valid with 0x0190, then raw_valid with 0x07D0 five cycles later → exactly one upd pulse, with values 25/77. A period wrap during busy produces sample_req on the first IDLE cycle.
6. Assert rst at DIV cycle 10 → all outputs 0 immediately, no upd. A fresh conversion after release completes normally.
